ds1302_ctrl: RTL and testbench

- Transaction scheduler in front of the DS1302 serial engine (addr/data/RW/valid in; busy/receive out).
- Periodically polls the seconds/minutes/hours registers and presents a coherent time snapshot to the display logic.
- Accepts single-register user writes and arbitrates them against polling.
- Wraps every user write in a write-protect clear / restore pair.

---
 rtl/ds1302_pkg.sv | 76 +++++++
 rtl/ds1302_poll_timer.sv | 27 ++
 rtl/ds1302_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ds1302_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 transaction scheduler: register indices,
// write-protect values, FSM state encoding and per-step transaction descriptors.
// Optional macro DS1302_CTRL_DATE_EN extends the read burst with date/month/year.
package ds1302_pkg;

  localparam logic [4:0] SEC   = 5'd0;
  localparam logic [4:0] MIN   = 5'd1;
  localparam logic [4:0] HOUR  = 5'd2;
  localparam logic [4:0] DATE  = 5'd3;
  localparam logic [4:0] MONTH = 5'd4;
  localparam logic [4:0] YEAR  = 5'd6;
  localparam logic [4:0] WP    = 5'd7;

  localparam logic [7:0] WP_CLR = 8'h00;
  localparam logic [7:0] WP_SET = 8'h80;

`ifdef DS1302_CTRL_DATE_EN
  localparam logic [2:0] RD_LAST = 3'd5;
`else
  localparam logic [2:0] RD_LAST = 3'd2;
`endif
  localparam logic [2:0] WR_LAST = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    NEXT
  } state_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
    logic       rw;
  } step_t;

  // Read burst order: sec, min, hour (then date, month, year when enabled).
  function automatic step_t rd_step(input logic [2:0] idx);
    step_t s;
    s.data = '0;
    s.rw   = 1'b1;
    case (idx)
      3'd0:    s.addr = SEC;
      3'd1:    s.addr = MIN;
      3'd2:    s.addr = HOUR;
      3'd3:    s.addr = DATE;
      3'd4:    s.addr = MONTH;
      default: s.addr = YEAR;
    endcase
    return s;
  endfunction

  // Write burst: clear WP, user register, restore WP.
  function automatic step_t wr_step(input logic [2:0] idx, input logic [4:0] addr,
                                    input logic [7:0] data);
    step_t s;
    s.rw = 1'b0;
    case (idx)
      3'd0: begin
        s.addr = WP;
        s.data = WP_CLR;
      end
      3'd1: begin
        s.addr = addr;
        s.data = data;
      end
      default: begin
        s.addr = WP;
        s.data = WP_SET;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ds1302_poll_timer.sv
// Free-running refresh timer: counts 0..POLL_CNT-1 and flags the wrap cycle.
module ds1302_poll_timer #(
  parameter int unsigned POLL_CNT = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic wrap
);

  localparam int unsigned CW = (POLL_CNT > 1) ? $clog2(POLL_CNT) : 1;

  logic [CW-1:0] cnt;

  assign wrap = (cnt == CW'(POLL_CNT - 1));

  // Period counter, restarts from zero on wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ds1302_ctrl.sv
// DS1302 transaction scheduler: periodic time polling with atomic snapshot
// update, plus WP-wrapped single-register user writes that preempt polling
// at transaction boundaries. Macro DS1302_CTRL_DATE_EN adds date/month/year.
module ds1302_ctrl
  import ds1302_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned POLL_MS  = 100,
  parameter int unsigned START_TO = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_wr_req,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_ready,
  output logic       o_wr_ack,
  output logic [4:0] o_ds_addr,
  output logic [7:0] o_ds_data,
  output logic       o_ds_rw,
  output logic       o_ds_valid,
  input  logic       i_ds_busy,
  input  logic [7:0] i_ds_rdata,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
`ifdef DS1302_CTRL_DATE_EN
  output logic [7:0] o_date,
  output logic [7:0] o_month,
  output logic [7:0] o_year,
`endif
  output logic       o_time_valid,
  output logic       o_err
);

  localparam int unsigned POLL_CNT = CLK_HZ / 1000 * POLL_MS;
  localparam int unsigned TW       = (START_TO > 1) ? $clog2(START_TO) : 1;

  state_t        state;
  logic [2:0]    step;
  logic          is_write;
  logic          wr_pending;
  logic          poll_pending;
  logic          poll_wrap;
  logic [4:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [TW-1:0] to_cnt;
  logic [6:0]    sh_sec;
  logic [7:0]    sh_min;
  logic [7:0]    sh_hour;
`ifdef DS1302_CTRL_DATE_EN
  logic [7:0]    sh_date;
  logic [7:0]    sh_month;
  logic [7:0]    sh_year;
`endif
  step_t         cur;

  ds1302_poll_timer #(
    .POLL_CNT(POLL_CNT)
  ) u_poll_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .wrap   (poll_wrap)
  );

  // Descriptor of the transaction for the current step of the active burst.
  always_comb begin
    cur = is_write ? wr_step(step, wr_addr, wr_data) : rd_step(step);
  end

  // Scheduler FSM with request capture, shadow capture and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step         <= '0;
      is_write     <= 1'b0;
      wr_pending   <= 1'b0;
      poll_pending <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      to_cnt       <= '0;
      sh_sec       <= '0;
      sh_min       <= '0;
      sh_hour      <= '0;
`ifdef DS1302_CTRL_DATE_EN
      sh_date      <= '0;
      sh_month     <= '0;
      sh_year      <= '0;
      o_date       <= '0;
      o_month      <= '0;
      o_year       <= '0;
`endif
      o_wr_ready   <= 1'b1;
      o_wr_ack     <= 1'b0;
      o_ds_addr    <= '0;
      o_ds_data    <= '0;
      o_ds_rw      <= 1'b0;
      o_ds_valid   <= 1'b0;
      o_sec        <= '0;
      o_min        <= '0;
      o_hour       <= '0;
      o_time_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_ds_valid   <= 1'b0;
      o_wr_ack     <= 1'b0;
      o_time_valid <= 1'b0;

      if (poll_wrap) begin
        poll_pending <= 1'b1;
      end

      if (i_wr_req && o_wr_ready) begin
        wr_pending <= 1'b1;
        wr_addr    <= i_wr_addr;
        wr_data    <= i_wr_data;
        o_wr_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_pending) begin
            wr_pending <= 1'b0;
            is_write   <= 1'b1;
            step       <= '0;
            state      <= ISSUE;
          end else if (poll_pending) begin
            poll_pending <= 1'b0;
            is_write     <= 1'b0;
            step         <= '0;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          if (!i_ds_busy) begin
            o_ds_addr  <= cur.addr;
            o_ds_data  <= cur.data;
            o_ds_rw    <= cur.rw;
            o_ds_valid <= 1'b1;
            to_cnt     <= '0;
            state      <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (i_ds_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TW'(START_TO - 1)) begin
            o_err <= 1'b1;
            state <= IDLE;
            if (is_write) begin
              o_wr_ready <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        WAIT_DONE: begin
          if (!i_ds_busy) begin
            if (!is_write) begin
              case (step)
                3'd0:    sh_sec   <= i_ds_rdata[6:0];
                3'd1:    sh_min   <= i_ds_rdata;
                3'd2:    sh_hour  <= i_ds_rdata;
`ifdef DS1302_CTRL_DATE_EN
                3'd3:    sh_date  <= i_ds_rdata;
                3'd4:    sh_month <= i_ds_rdata;
                3'd5:    sh_year  <= i_ds_rdata;
`endif
                default: ;
              endcase
            end else if (step == WR_LAST) begin
              o_wr_ack <= 1'b1;
            end
            state <= NEXT;
          end
        end

        NEXT: begin
          if (is_write && step == WR_LAST) begin
            o_wr_ready <= 1'b1;
            state      <= IDLE;
          end else if (!is_write && step == RD_LAST) begin
            o_sec        <= {1'b0, sh_sec};
            o_min        <= sh_min;
            o_hour       <= sh_hour;
`ifdef DS1302_CTRL_DATE_EN
            o_date       <= sh_date;
            o_month      <= sh_month;
            o_year       <= sh_year;
`endif
            o_time_valid <= 1'b1;
            state        <= IDLE;
          end else if (!is_write && wr_pending) begin
            // Drop the partial burst and re-arm polling so it restarts at SEC
            // once the write (picked first in IDLE) has completed.
            poll_pending <= 1'b1;
            state        <= IDLE;
          end else begin
            step  <= step + 3'd1;
            state <= ISSUE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Scoreboard bench for ds1302_ctrl with a behavioural DS1302 engine/register model.
module tb_ds1302_ctrl;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned POLL_MS  = 8000;
  localparam int unsigned START_TO = 64;

  logic       clk;
  logic       reset_n;
  logic       i_wr_req;
  logic [4:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       o_wr_ack;
  logic [4:0] o_ds_addr;
  logic [7:0] o_ds_data;
  logic       o_ds_rw;
  logic       o_ds_valid;
  logic       i_ds_busy;
  logic [7:0] i_ds_rdata;
  logic [7:0] o_sec;
  logic [7:0] o_min;
  logic [7:0] o_hour;
`ifdef DS1302_CTRL_DATE_EN
  logic [7:0] o_date;
  logic [7:0] o_month;
  logic [7:0] o_year;
`endif
  logic       o_time_valid;
  logic       o_err;

  ds1302_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .POLL_MS (POLL_MS),
    .START_TO(START_TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_wr_req    (i_wr_req),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_wr_ready  (o_wr_ready),
    .o_wr_ack    (o_wr_ack),
    .o_ds_addr   (o_ds_addr),
    .o_ds_data   (o_ds_data),
    .o_ds_rw     (o_ds_rw),
    .o_ds_valid  (o_ds_valid),
    .i_ds_busy   (i_ds_busy),
    .i_ds_rdata  (i_ds_rdata),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
`ifdef DS1302_CTRL_DATE_EN
    .o_date      (o_date),
    .o_month     (o_month),
    .o_year      (o_year),
`endif
    .o_time_valid(o_time_valid),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  dev  [8];   // device register file inside the engine model
  logic [7:0]  refr [8];   // bench's expectation of device contents
  bit          eng_dead = 1'b0;
  int          bmin = 200;
  int          bmax = 200;

  logic [13:0] exp_txn[$];
  logic [23:0] exp_time[$];
  int          exp_acks = 0;
  int          n_strobe = 0;
  int          n_time = 0;
  int          n_ack = 0;
  bit          prev_valid = 1'b0;
  bit          prev_tv = 1'b0;
  bit          prev_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input logic [4:0] a);
    exp_txn.push_back({a, 8'h00, 1'b1});
  endtask

  task automatic push_read_burst();
    push_rd(5'd0);
    push_rd(5'd1);
    push_rd(5'd2);
`ifdef DS1302_CTRL_DATE_EN
    push_rd(5'd3);
    push_rd(5'd4);
    push_rd(5'd6);
`endif
    exp_time.push_back({refr[0] & 8'h7F, refr[1], refr[2]});
  endtask

  task automatic set_time(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    dev[0] = s; dev[1] = m; dev[2] = h;
    refr[0] = s; refr[1] = m; refr[2] = h;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    exp_txn.push_back({5'd7, 8'h00, 1'b0});
    exp_txn.push_back({a, d, 1'b0});
    exp_txn.push_back({5'd7, 8'h80, 1'b0});
    refr[a] = d;
    refr[7] = 8'h80;
    exp_acks++;
    i_wr_addr = a;
    i_wr_data = d;
    i_wr_req  = 1'b1;
    @(negedge clk);
    i_wr_req  = 1'b0;
    chk("ready_drop", {31'd0, o_wr_ready}, 32'd0);
  endtask

  function automatic int cur_count(input int kind);
    case (kind)
      0:       return n_time;
      1:       return n_ack;
      2:       return n_strobe;
      default: return int'(o_err);
    endcase
  endfunction

  // Bounded wait for an observed event count; expiry is reported as a failure.
  task automatic wait_evt(input string name, input int kind, input int target, input int budget);
    int cyc = 0;
    while (cur_count(kind) < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, cur_count(kind), target);
  endtask

  // Engine model: busy rises after a strobe, reads return device contents on busy fall.
  initial begin
    logic [4:0] a;
    logic [7:0] d;
    logic       rw;
    int         len;
    i_ds_busy  = 1'b0;
    i_ds_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n && o_ds_valid && !eng_dead) begin
        a   = o_ds_addr;
        d   = o_ds_data;
        rw  = o_ds_rw;
        len = $urandom_range(bmax, bmin);
        i_ds_busy  = 1'b1;
        i_ds_rdata = 8'($urandom);
        repeat (len) @(negedge clk);
        if (rw) i_ds_rdata = dev[a[2:0]];
        else    dev[a[2:0]] = d;
        i_ds_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe, snapshot or ack.
  always @(negedge clk) begin
    logic [13:0] e;
    logic [23:0] t;
    if (reset_n) begin
      if (prev_valid) chk("ds_valid_width", {31'd0, o_ds_valid}, 32'd0);
      if (prev_tv)    chk("time_valid_width", {31'd0, o_time_valid}, 32'd0);
      if (prev_ack)   chk("ready_after_ack", {31'd0, o_wr_ready}, 32'd1);
      if (o_ds_valid) begin
        n_strobe++;
        if (exp_txn.size() == 0) begin
          chk("txn_unexpected", {18'd0, o_ds_addr, o_ds_data, o_ds_rw}, 32'h3FFF_FFFF);
        end else begin
          e = exp_txn.pop_front();
          if (e[0]) chk("txn_read", {26'd0, o_ds_addr, o_ds_rw}, {26'd0, e[13:9], e[0]});
          else      chk("txn_write", {18'd0, o_ds_addr, o_ds_data, o_ds_rw}, {18'd0, e});
        end
      end
      if (o_time_valid) begin
        n_time++;
        if (exp_time.size() == 0) begin
          chk("time_unexpected", {8'd0, o_sec, o_min, o_hour}, 32'hFFFF_FFFF);
        end else begin
          t = exp_time.pop_front();
          chk("time_snapshot", {8'd0, o_sec, o_min, o_hour}, {8'd0, t});
        end
      end
      if (o_wr_ack) begin
        n_ack++;
        chk("ack_expected", {31'd0, exp_acks > 0}, 32'd1);
        exp_acks--;
        chk("ready_during_ack", {31'd0, o_wr_ready}, 32'd0);
      end
    end
    prev_valid = reset_n && o_ds_valid;
    prev_tv    = reset_n && o_time_valid;
    prev_ack   = reset_n && o_wr_ack;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, o_wr_ready}, 32'd1);
    chk({tag, "_zero"}, {9'd0, o_wr_ack, o_ds_valid, o_time_valid, o_err, o_sec, o_min, o_hour},
        32'd0);
    chk({tag, "_ds"}, {18'd0, o_ds_addr, o_ds_data, o_ds_rw}, 32'd0);
  endtask

  initial begin
    int s0;
    int t0;
    logic [7:0] d;
    reset_n   = 1'b0;
    i_wr_req  = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    for (int i = 0; i < 8; i++) begin
      dev[i]  = 8'h00;
      refr[i] = 8'h00;
    end

    // Reset state, then first poll burst with fixed 200-cycle busy.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    set_time(8'hD9, 8'h34, 8'h12);
    push_read_burst();
    reset_n = 1'b1;
    wait_evt("first_poll", 0, 1, 12000);

    // Idle write, then a random write with an ignored second request.
    repeat (20) @(negedge clk);
    do_write(5'd1, 8'h45);
    wait_evt("idle_write_ack", 1, 1, 3000);
    repeat (2) @(negedge clk);
    chk("ready_after_write", {31'd0, o_wr_ready}, 32'd1);
    bmin = 20;
    bmax = 200;
    do_write(5'($urandom_range(5, 3)), 8'($urandom));
    repeat (10) @(negedge clk);
    chk("ready_while_busy", {31'd0, o_wr_ready}, 32'd0);
    i_wr_addr = 5'd6;
    i_wr_data = 8'($urandom);
    i_wr_req  = 1'b1;
    @(negedge clk);
    i_wr_req  = 1'b0;
    wait_evt("second_write_ack", 1, 2, 3000);
    repeat (5) @(negedge clk);
    chk("single_ack", n_ack, 2);

    // Write arrives during the min read of a poll burst.
    set_time(8'($urandom), 8'($urandom), 8'($urandom));
    push_rd(5'd0);
    push_rd(5'd1);
    s0 = n_strobe;
    t0 = n_time;
    wait_evt("preempt_min_strobe", 2, s0 + 2, 12000);
    d = 8'($urandom);
    do_write(5'd0, d);
    push_read_burst();
    wait_evt("preempt_ack", 1, 3, 6000);
    wait_evt("preempt_time", 0, t0 + 1, 6000);

    // Engine never raises busy: timeout, then the following poll recovers.
    eng_dead = 1'b1;
    push_rd(5'd0);
    t0 = n_time;
    wait_evt("timeout_err", 3, 1, 12000);
    repeat (3) @(negedge clk);
    chk("timeout_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("timeout_no_time", n_time, t0);
    eng_dead = 1'b0;
    set_time(8'($urandom), 8'($urandom), 8'($urandom));
    push_read_burst();
    wait_evt("poll_after_timeout", 0, t0 + 1, 12000);
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset asserted while the min read is in WAIT_DONE.
    bmin = 200;
    bmax = 200;
    set_time(8'($urandom), 8'($urandom), 8'($urandom));
    push_read_burst();
    s0 = n_strobe;
    wait_evt("reset_min_strobe", 2, s0 + 2, 12000);
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_txn.delete();
    exp_time.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    push_read_burst();
    t0 = n_time;
    wait_evt("poll_after_reset", 0, t0 + 1, 12000);

    repeat (5) @(negedge clk);
    chk("txn_queue_empty", exp_txn.size(), 0);
    chk("time_queue_empty", exp_time.size(), 0);
    chk("acks_outstanding", exp_acks, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
